// File: rtl/div_pkg.sv
// Shared divide definitions: command codes, FSM encoding and iteration count.
// Also used by the divide control sequencer.
package div_pkg;

    localparam int WIDTH      = 32;
    localparam int DIV_CYCLES = 32;
    localparam int CNT_W      = $clog2(DIV_CYCLES);

    localparam logic [5:0] OP_DIV  = 6'b011010;
    localparam logic [5:0] OP_DIVU = 6'b011011;
    localparam logic [5:0] OP_OUT  = 6'b111111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem,quo} left, subtract divisor if it fits.
// Latency: combinational. Backpressure: none.
// rem is one bit wider than the operands so the shifted-in carry is never lost.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH+1:0] rem_sh;
    logic [WIDTH+1:0] div_ext;

    always_comb begin
        rem_sh   = {rem, quo[WIDTH-1]};
        div_ext  = {2'b00, divisor};
        rem_next = rem_sh[WIDTH:0];
        quo_next = {quo[WIDTH-2:0], 1'b0};
        if (rem_sh >= div_ext) begin
            rem_next = (WIDTH+1)'(rem_sh - div_ext);
            quo_next = {quo[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/hilo_divider.sv
// Multi-cycle signed/unsigned divider that commits {remainder,quotient} to HI/LO on OUT.
// Latency: 32 CALC + 1 FIXUP cycles after the start edge; result held in DONE until OUT.
// Backpressure: none; commands arriving while busy are dropped, OUT only acts in DONE.
module hilo_divider
    import div_pkg::*;
#(
    parameter int WIDTH = div_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       op,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    output logic             busy,
    output logic             ready,
    output logic             hilo_we,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    div_state_t       state;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] divisor;
    logic [CNT_W-1:0] count;
    logic             sign_q;
    logic             sign_r;

    logic [WIDTH:0]   rem_next;
    logic [WIDTH-1:0] quo_next;

    logic             start;
    logic             neg_a;
    logic             neg_b;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    // Operand magnitudes are computed up front so IDLE and DONE share one start path.
    always_comb begin
        start = (op == OP_DIV) || (op == OP_DIVU);
        neg_a = (op == OP_DIV) && dataA[WIDTH-1];
        neg_b = (op == OP_DIV) && dataB[WIDTH-1];
        mag_a = neg_a ? -dataA : dataA;
        mag_b = neg_b ? -dataB : dataB;
    end

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem),
        .quo      (quo),
        .divisor  (divisor),
        .rem_next (rem_next),
        .quo_next (quo_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            rem     <= '0;
            quo     <= '0;
            divisor <= '0;
            count   <= '0;
            sign_q  <= 1'b0;
            sign_r  <= 1'b0;
            busy    <= 1'b0;
            ready   <= 1'b0;
            hilo_we <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            hilo_we <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (state == DONE && op == OP_OUT) begin
                        hi      <= rem[WIDTH-1:0];
                        lo      <= quo;
                        hilo_we <= 1'b1;
                        ready   <= 1'b0;
                        state   <= IDLE;
                    end else if (start) begin
                        rem     <= '0;
                        quo     <= mag_a;
                        divisor <= mag_b;
                        sign_q  <= neg_a ^ neg_b;
                        sign_r  <= neg_a;
                        count   <= '0;
                        busy    <= 1'b1;
                        ready   <= 1'b0;
                        state   <= CALC;
                    end
                end
                CALC: begin
                    rem   <= rem_next;
                    quo   <= quo_next;
                    count <= count + 1'b1;
                    if (count == CNT_W'(DIV_CYCLES - 1))
                        state <= FIXUP;
                end
                FIXUP: begin
                    if (sign_q)
                        quo <= -quo;
                    if (sign_r)
                        rem <= {1'b0, -rem[WIDTH-1:0]};
                    busy  <= 1'b0;
                    ready <= 1'b1;
                    state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_divider.sv
// Directed bench for hilo_divider: vector table of divides plus protocol/reset sequences.
module tb_hilo_divider;
    import div_pkg::*;

    logic        clk;
    logic        rst;
    logic [5:0]  op;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic        busy;
    logic        ready;
    logic        hilo_we;
    logic [31:0] hi;
    logic [31:0] lo;

    localparam logic [5:0] OP_NOP = 6'd0;

    int n_pass = 0;
    int n_tot  = 0;
    int overlap = 0;

    hilo_divider dut (
        .clk     (clk),
        .rst     (rst),
        .op      (op),
        .dataA   (dataA),
        .dataB   (dataB),
        .busy    (busy),
        .ready   (ready),
        .hilo_we (hilo_we),
        .hi      (hi),
        .lo      (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        string       name;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Advance one clock and settle just past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (hilo_we && busy)
            overlap++;
    endtask

    // Start at cycle 0, hold the command through FIXUP, OUT at cycle 34.
    task automatic do_div(input logic [5:0] opc, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo, input string nm);
        int we_seen;
        we_seen = 0;
        op = opc; dataA = a; dataB = b;
        tick();
        chk({nm, " busy@1"}, busy, 1);
        repeat (32) begin
            tick();
            if (hilo_we) we_seen++;
        end
        chk({nm, " busy@33"}, busy, 1);
        chk({nm, " ready@33"}, ready, 0);
        tick();
        chk({nm, " ready@34"}, ready, 1);
        chk({nm, " busy@34"}, busy, 0);
        op = OP_OUT;
        tick();
        chk({nm, " we@35"}, hilo_we, 1);
        chk({nm, " hi"}, hi, exp_hi);
        chk({nm, " lo"}, lo, exp_lo);
        op = OP_NOP;
        tick();
        chk({nm, " we@36"}, hilo_we, 0);
        chk({nm, " ready@36"}, ready, 0);
        chk({nm, " hi held"}, hi, exp_hi);
        chk({nm, " early we"}, we_seen, 0);
    endtask

    initial begin
        int pulses;
        int we_seen;

        vecs[0] = '{OP_DIVU, 32'd100,        32'd7,        32'd2,        32'd14,       "divu 100/7"};
        vecs[1] = '{OP_DIV,  32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, "div -7/2"};
        vecs[2] = '{OP_DIV,  32'd7,          32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, "div 7/-2"};
        vecs[3] = '{OP_DIVU, 32'd5,          32'd0,        32'd5,        32'hFFFFFFFF, "divu 5/0"};
        vecs[4] = '{OP_DIV,  32'h80000000,   32'hFFFFFFFF, 32'd0,        32'h80000000, "div ovf"};
        vecs[5] = '{OP_DIVU, 32'hFFFFFFFF,   32'd1,        32'd0,        32'hFFFFFFFF, "divu max/1"};
        vecs[6] = '{OP_DIV,  32'hFFFFFF9C,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'd14,       "div -100/-7"};
        vecs[7] = '{OP_DIVU, 32'h80000000,   32'd3,        32'd2,        32'h2AAAAAAA, "divu 2^31/3"};
        vecs[8] = '{OP_DIVU, 32'd3,          32'd10,       32'd3,        32'd0,        "divu 3/10"};

        rst = 1'b1; op = OP_NOP; dataA = '0; dataB = '0;
        tick();
        tick();
        chk("rst busy", busy, 0);
        chk("rst ready", ready, 0);
        chk("rst we", hilo_we, 0);
        chk("rst hi", hi, 0);
        chk("rst lo", lo, 0);
        @(negedge clk) rst = 1'b0;
        tick();

        for (int i = 0; i < 9; i++)
            do_div(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].name);

        // OUT while busy is ignored; a new start mid-divide is ignored; OUT held 3 cycles.
        op = OP_DIVU; dataA = 32'd100; dataB = 32'd7;
        tick();
        op = OP_NOP;
        repeat (9) tick();
        op = OP_OUT;
        tick();
        chk("out@10 we", hilo_we, 0);
        chk("out@10 busy", busy, 1);
        op = OP_NOP;
        repeat (4) tick();
        op = OP_DIVU; dataA = 32'd1000; dataB = 32'd3;
        tick();
        op = OP_NOP;
        repeat (18) tick();
        chk("proto ready@34", ready, 1);
        pulses = 0;
        op = OP_OUT;
        tick();
        if (hilo_we) pulses++;
        chk("proto hi", hi, 32'd2);
        chk("proto lo", lo, 32'd14);
        repeat (2) begin
            tick();
            if (hilo_we) pulses++;
        end
        chk("proto pulses", pulses, 1);
        op = OP_NOP;
        tick();

        // Asynchronous reset in the middle of CALC.
        op = OP_DIVU; dataA = 32'd100; dataB = 32'd7;
        tick();
        op = OP_NOP;
        repeat (19) tick();
        #2 rst = 1'b1;
        #1;
        chk("midrst busy", busy, 0);
        chk("midrst ready", ready, 0);
        chk("midrst we", hilo_we, 0);
        chk("midrst hi", hi, 0);
        chk("midrst lo", lo, 0);
        @(negedge clk) rst = 1'b0;
        do_div(OP_DIVU, 32'd9, 32'd3, 32'd0, 32'd3, "post-rst 9/3");

        // Restart from DONE without OUT: first result is dropped.
        we_seen = 0;
        op = OP_DIVU; dataA = 32'd100; dataB = 32'd7;
        tick();
        op = OP_NOP;
        repeat (33) begin
            tick();
            if (hilo_we) we_seen++;
        end
        chk("b2b ready1", ready, 1);
        op = OP_DIVU; dataA = 32'd50; dataB = 32'd6;
        tick();
        chk("b2b restart busy", busy, 1);
        chk("b2b restart ready", ready, 0);
        op = OP_NOP;
        repeat (33) begin
            tick();
            if (hilo_we) we_seen++;
        end
        chk("b2b ready2", ready, 1);
        chk("b2b no early we", we_seen, 0);
        op = OP_OUT;
        tick();
        chk("b2b we", hilo_we, 1);
        chk("b2b hi", hi, 32'd2);
        chk("b2b lo", lo, 32'd8);
        op = OP_NOP;
        tick();

        chk("we with busy", overlap, 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/hilo_divider.md
Name: hilo_divider

Overview:
- Multi-cycle 32-bit divider that acts as the responder to the divide control sequencer.
- Accepts the 6-bit divide command code, latches operands, and iterates one quotient bit per cycle.
- Holds the result until the sequencer issues the OUT code, then pulses a write into the HI/LO register pair.
- Sits in the EX stage beside the ALU; its HI/LO write port feeds the HiLo register.

Parameters:
WIDTH, 32, operand/result width in bits
OP_DIV, 6'b011010, command code: signed divide start
OP_DIVU, 6'b011011, command code: unsigned divide start
OP_OUT, 6'b111111, command code: commit result to HI/LO

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
op  input  6  command code from divide control; any value not listed above is a no-op
dataA  input  WIDTH  dividend
dataB  input  WIDTH  divisor
busy  output  1  high in CALC and FIXUP
ready  output  1  high in DONE (result held, awaiting OUT)
hilo_we  output  1  one-cycle write strobe to HI/LO
hi  output  WIDTH  remainder, valid when hilo_we is high
lo  output  WIDTH  quotient, valid when hilo_we is high

Behaviour:
- Reset (async, any time including mid-divide):
  - state=IDLE; busy, ready and hilo_we = 0; hi and lo = 0.
  - Internal remainder, quotient, count and sign flags cleared.
- States: IDLE, CALC, FIXUP, DONE.
- IDLE:
  - On a clock edge with op==OP_DIV or op==OP_DIVU, latch the operands.
  - Signed op: store |dataA| and |dataB| and record sign_q = signA^signB and sign_r = signA. Unsigned op: store the raw operands, both signs 0.
  - Set count=0 and go to CALC. Every other op is ignored.
- CALC:
  - Restoring division, one bit per cycle.
  - Per cycle: {rem,quo} shifted left by 1; if rem_shifted >= divisor then subtract it and set quo[0]=1.
  - rem is held in WIDTH+1 bits so no carry is lost.
  - count increments each cycle; after 32 CALC cycles go to FIXUP.
- FIXUP (1 cycle):
  - Negate quo if sign_q; negate rem if sign_r. Two's complement, truncated to WIDTH.
  - Go to DONE.
- Latency: start edge at cycle 0; CALC covers cycles 1-32; FIXUP is cycle 33; ready=1 from cycle 34. This meets the sequencer issuing OUT at its count 35.
- DONE:
  - ready=1 and the result is held indefinitely.
  - op==OP_OUT: drive hi=rem and lo=quo with hilo_we=1 for exactly one cycle, then go to IDLE. hi and lo keep their value afterward; hilo_we returns to 0.
  - op==OP_DIV/OP_DIVU in DONE: discard the result, latch new operands, go to CALC (same as IDLE start).
- OP_OUT in IDLE, CALC or FIXUP: ignored, no hilo_we.
- OP_DIV/OP_DIVU in CALC or FIXUP: ignored. Operands are not re-latched and the operation in flight completes.
- Divide by zero: no special path. The restoring algorithm yields quo = all ones (before sign fixup) and rem = |dividend|.
  - Unsigned: lo=32'hFFFFFFFF, hi=dataA.
  - Signed: sign fixup applies; this is architecturally undefined and documented only.
- Overflow: signed 0x80000000 / -1 gives lo=0x80000000, hi=0. This follows naturally from 32-bit truncation; no trap.
- hilo_we is never high in the same cycle as busy.

Decomposition:
- Shared package div_pkg holds:
  - the op codes OP_DIV, OP_DIVU, OP_OUT (also used by the divide control sequencer);
  - the state encoding (2-bit IDLE=0, CALC=1, FIXUP=2, DONE=3);
  - the constant DIV_CYCLES=32.
- One natural sub-module: div_step. It is combinational: it takes {rem,quo} and the divisor and returns the next {rem,quo} for a single restoring iteration. It is instantiated once inside hilo_divider.

Test Plan:
- Unsigned divide: op=DIVU, A=100, B=7; hold op until OUT at cycle 35 -> ready at cycle 34, hilo_we at 35, lo=14, hi=2.
- Signed divide: op=DIV, A=-7 (0xFFFFFFF9), B=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; A=7, B=-2 -> lo=0xFFFFFFFD, hi=1.
- Corner cases: DIVU A=5, B=0 -> lo=0xFFFFFFFF, hi=5; DIV A=0x80000000, B=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Protocol: OUT issued at cycle 10 -> no hilo_we and busy stays 1. DIVU with new operands at cycle 15 is ignored: the original result is produced. OUT held in DONE for 3 cycles -> exactly one hilo_we pulse.
- Reset mid-CALC at cycle 20 -> busy, ready, hilo_we, hi, lo = 0 immediately (async). A new DIVU of 9/3 afterwards gives lo=3, hi=0.
- Back-to-back: in DONE, issue DIVU A=50, B=6 without OUT -> restart; then OUT -> lo=8, hi=2, with no write from the first result.
